usb_fs_nb_out_buf: RTL and testbench

- Packet store directly downstream of the non-buffered OUT/SETUP protocol engine.
- Captures the engine's byte-put stream into a ring of packet buffers and commits a buffer on ACK. Discards it on rollback.
- Drives the per-endpoint full flags back to the engine.
- Presents committed packets in arrival order to the device register interface via a valid/ready descriptor port and a read port.

---
 rtl/usb_fs_nb_out_buf.sv | 201 ++++++++++++++++++++
 tb/tb_usb_fs_nb_out_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_nb_out_buf.sv
// usb_fs_nb_out_buf
//   Packet store behind the non-buffered OUT/SETUP protocol engine. Captures
//   the engine's byte-put stream into a ring of NumBufs packet buffers. A
//   buffer is committed on ACK and discarded on rollback. Committed packets
//   are presented in arrival order through a valid/ready descriptor port and
//   a registered read port.
//
// Ports
//   clk_48mhz_i, rst_i       clock, asynchronous active-high reset
//   link_reset_i             USB bus reset: flush in-progress capture
//   out_ep_*_i               engine byte-put / commit / rollback stream
//   out_ep_full_o            per-EP "cannot accept" back to the engine
//   out_enable_i             software enable per OUT endpoint
//   rx_valid_o/rx_ready_i    head descriptor handshake
//   rx_ep_o/rx_setup_o/rx_size_o/rx_ovf_o   head descriptor fields
//   rd_addr_i/rd_data_o      head buffer byte read, 1-cycle latency
//   rx_depth_o               committed buffer count
//
// Build option
//   USB_OUT_BUF_SETUP_RESERVE_EN : keep the last free buffer for SETUP.
module usb_fs_nb_out_buf #(
    parameter  int unsigned NumOutEps         = 2,
    parameter  int unsigned MaxOutPktSizeByte = 32,
    parameter  int unsigned NumBufs           = 4,
    localparam int unsigned PktW              = $clog2(MaxOutPktSizeByte),
    localparam int unsigned BufW              = $clog2(NumBufs)
) (
    input  logic                 clk_48mhz_i,
    input  logic                 rst_i,
    input  logic                 link_reset_i,
    input  logic [3:0]           out_ep_current_i,
    input  logic                 out_ep_newpkt_i,
    input  logic                 out_ep_data_put_i,
    input  logic [PktW-1:0]      out_ep_put_addr_i,
    input  logic [7:0]           out_ep_data_i,
    input  logic                 out_ep_acked_i,
    input  logic                 out_ep_rollback_i,
    input  logic [NumOutEps-1:0] out_ep_setup_i,
    output logic [NumOutEps-1:0] out_ep_full_o,
    input  logic [NumOutEps-1:0] out_enable_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [3:0]           rx_ep_o,
    output logic                 rx_setup_o,
    output logic [PktW:0]        rx_size_o,
    output logic                 rx_ovf_o,
    input  logic [PktW-1:0]      rd_addr_i,
    output logic [7:0]           rd_data_o,
    output logic [BufW:0]        rx_depth_o
);

    typedef enum logic [1:0] {StIdle, StFill, StDrop} state_e;

    localparam logic [BufW:0] CntMax  = (BufW+1)'(NumBufs);
    localparam logic [BufW:0] CntRes  = CntMax - 1'b1;
    localparam logic [PktW:0] SizeMax = (PktW+1)'(MaxOutPktSizeByte);

    state_e          state_q, state_d;
    logic [3:0]      ep_q, ep_d;
    logic            setup_q, setup_d;
    logic [PktW:0]   size_q, size_d;
    logic            ovf_q, ovf_d;
    logic [BufW-1:0] wr_ptr_q, rd_ptr_q;
    logic [BufW:0]   cnt_q, cnt_d;
    logic [7:0]      rd_data_q;

    logic [7:0]      mem_q [NumBufs*MaxOutPktSizeByte];
    logic [3:0]      dsc_ep_q    [NumBufs];
    logic            dsc_setup_q [NumBufs];
    logic [PktW:0]   dsc_size_q  [NumBufs];
    logic            dsc_ovf_q   [NumBufs];

    logic cur_valid, cur_en, cur_setup, room;
    logic push, pop, mem_we;

    // Look up the current endpoint without indexing past NumOutEps.
    always_comb begin
        cur_valid = 1'b0;
        cur_en    = 1'b0;
        cur_setup = 1'b0;
        for (int unsigned e = 0; e < NumOutEps; e++) begin
            if (out_ep_current_i == 4'(e)) begin
                cur_valid = 1'b1;
                cur_en    = out_enable_i[e];
                cur_setup = out_ep_setup_i[e];
            end
        end
    end

`ifdef USB_OUT_BUF_SETUP_RESERVE_EN
    assign room = cur_setup ? (cnt_q < CntMax) : (cnt_q < CntRes);
`else
    assign room = (cnt_q < CntMax);
`endif

    always_comb begin
        for (int unsigned e = 0; e < NumOutEps; e++) begin
            out_ep_full_o[e] = !out_enable_i[e] || (cnt_q == CntMax);
`ifdef USB_OUT_BUF_SETUP_RESERVE_EN
            if (cnt_q >= CntRes && !out_ep_setup_i[e]) out_ep_full_o[e] = 1'b1;
`endif
        end
    end

    assign rx_valid_o = (cnt_q != '0);
    assign pop        = rx_valid_o && rx_ready_i;

    // newpkt overrides whatever the current state is doing, so an
    // unfinished fill is simply abandoned without a commit.
    always_comb begin
        state_d = state_q;
        ep_d    = ep_q;
        setup_d = setup_q;
        size_d  = size_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        mem_we  = 1'b0;
        if (link_reset_i) begin
            state_d = StIdle;
        end else if (out_ep_newpkt_i) begin
            ep_d    = out_ep_current_i;
            setup_d = cur_setup;
            size_d  = '0;
            ovf_d   = 1'b0;
            state_d = (cur_valid && cur_en && room) ? StFill : StDrop;
        end else begin
            case (state_q)
                StFill: begin
                    if (out_ep_rollback_i) begin
                        state_d = StIdle;
                    end else if (out_ep_acked_i) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else if (out_ep_data_put_i) begin
                        mem_we = 1'b1;
                        if (size_q == SizeMax) ovf_d  = 1'b1;
                        else                   size_d = size_q + 1'b1;
                    end
                end
                StDrop: begin
                    if (out_ep_rollback_i || out_ep_acked_i) state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ep_q      <= '0;
            setup_q   <= 1'b0;
            size_q    <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            for (int unsigned i = 0; i < NumBufs; i++) begin
                dsc_ep_q[i]    <= '0;
                dsc_setup_q[i] <= 1'b0;
                dsc_size_q[i]  <= '0;
                dsc_ovf_q[i]   <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            ep_q      <= ep_d;
            setup_q   <= setup_d;
            size_q    <= size_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rd_data_q <= mem_q[{rd_ptr_q, rd_addr_i}];
            if (push) begin
                dsc_ep_q[wr_ptr_q]    <= ep_q;
                dsc_setup_q[wr_ptr_q] <= setup_q;
                dsc_size_q[wr_ptr_q]  <= size_q;
                dsc_ovf_q[wr_ptr_q]   <= ovf_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz_i) begin
        if (mem_we) mem_q[{wr_ptr_q, out_ep_put_addr_i}] <= out_ep_data_i;
    end

    assign rx_ep_o    = dsc_ep_q[rd_ptr_q];
    assign rx_setup_o = dsc_setup_q[rd_ptr_q];
    assign rx_size_o  = dsc_size_q[rd_ptr_q];
    assign rx_ovf_o   = dsc_ovf_q[rd_ptr_q];
    assign rd_data_o  = rd_data_q;
    assign rx_depth_o = cnt_q;

endmodule

// File: tb/tb_usb_fs_nb_out_buf.sv
module tb_usb_fs_nb_out_buf;

    typedef struct packed {
        logic [3:0] ep;
        logic       setup;
        logic [5:0] size;
        logic       ovf;
    } desc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_reset;
    logic [3:0] ep_cur;
    logic       newpkt, put, acked, rollback, rx_ready;
    logic [4:0] put_addr, rd_addr;
    logic [7:0] put_data, rd_data;
    logic [1:0] setup_v, full, enable;
    logic       rx_valid, rx_setup, rx_ovf;
    logic [3:0] rx_ep;
    logic [5:0] rx_size;
    logic [2:0] depth;

    int   vectors = 0;
    int   miscompares = 0;
    int   mcnt = 0;
    desc_t exp_q[$];

    always #5 clk = ~clk;

    usb_fs_nb_out_buf #(.NumOutEps(2), .MaxOutPktSizeByte(32), .NumBufs(4)) dut (
        .clk_48mhz_i(clk), .rst_i(rst), .link_reset_i(link_reset),
        .out_ep_current_i(ep_cur), .out_ep_newpkt_i(newpkt),
        .out_ep_data_put_i(put), .out_ep_put_addr_i(put_addr),
        .out_ep_data_i(put_data), .out_ep_acked_i(acked),
        .out_ep_rollback_i(rollback), .out_ep_setup_i(setup_v),
        .out_ep_full_o(full), .out_enable_i(enable),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_ep_o(rx_ep),
        .rx_setup_o(rx_setup), .rx_size_o(rx_size), .rx_ovf_o(rx_ovf),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rx_depth_o(depth)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head descriptor is compared with the
    // oldest expected one.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_desc", 32'(rx_valid), 32'(0));
            end else begin
                desc_t e;
                e = exp_q.pop_front();
                check("desc_ep", 32'(rx_ep), 32'(e.ep));
                check("desc_setup", 32'(rx_setup), 32'(e.setup));
                check("desc_size", 32'(rx_size), 32'(e.size));
                check("desc_ovf", 32'(rx_ovf), 32'(e.ovf));
            end
        end
    end

    function automatic logic [1:0] exp_full(input logic [1:0] en, input logic [1:0] su, input int c);
        logic [1:0] f;
        for (int e = 0; e < 2; e++) begin
            f[e] = !en[e] || (c == 4);
`ifdef USB_OUT_BUF_SETUP_RESERVE_EN
            if (c >= 3 && !su[e]) f[e] = 1'b1;
`endif
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input int ep, input bit setup);
        ep_cur  = 4'(ep);
        setup_v = (setup && ep < 2) ? 2'(1 << ep) : 2'b00;
        newpkt  = 1'b1;
        tick();
        newpkt  = 1'b0;
    endtask

    task automatic put_byte(input int addr, input int data);
        put      = 1'b1;
        put_addr = 5'(addr);
        put_data = 8'(data);
        tick();
        put      = 1'b0;
    endtask

    // Whole transfer; commit decision comes from the bench's own model of
    // enables and buffer occupancy.
    task automatic send(input int ep, input bit setup, input int n, input int base, input bit pop_too);
        bit    commit;
        int    lim;
        desc_t d;
`ifdef USB_OUT_BUF_SETUP_RESERVE_EN
        lim = setup ? 4 : 3;
`else
        lim = 4;
`endif
        commit = (ep < 2) && enable[ep] && (mcnt < lim);
        start_pkt(ep, setup);
        for (int i = 0; i < n; i++) put_byte((i < 32) ? i : 31, base + i);
        if (commit) begin
            d.ep    = 4'(ep);
            d.setup = setup;
            d.size  = (n > 32) ? 6'd32 : 6'(n);
            d.ovf   = (n > 32);
            exp_q.push_back(d);
            mcnt++;
        end
        if (pop_too) begin
            rx_ready = 1'b1;
            mcnt--;
        end
        acked = 1'b1;
        tick();
        acked    = 1'b0;
        rx_ready = 1'b0;
        setup_v  = 2'b00;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        mcnt--;
    endtask

    task automatic read_chk(input string name, input int addr, input int exp);
        rd_addr = 5'(addr);
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; link_reset = 1'b0; ep_cur = '0; newpkt = 1'b0; put = 1'b0;
        acked = 1'b0; rollback = 1'b0; rx_ready = 1'b0; put_addr = '0;
        put_data = '0; rd_addr = '0; setup_v = '0; enable = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("rst_full", 32'(full), 32'(2'b01));
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(rx_valid), 32'(0));
        check("rst_depth", 32'(depth), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        enable = 2'b11;
        #1;
        check("full_enabled", 32'(full), 32'(0));

        // Basic OUT to EP1 and registered read
        send(1, 1'b0, 8, 8'h10, 1'b0);
        check("valid_after_ack", 32'(rx_valid), 32'(1));
        check("depth_1", 32'(depth), 32'(1));
        read_chk("rd_addr3", 3, 8'h13);
        pop_one();
        check("depth_after_pop", 32'(depth), 32'(0));

        // Rollback discards, next packet lands in the same slot
        start_pkt(1, 1'b0);
        for (int i = 0; i < 5; i++) put_byte(i, 8'h90 + i);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rollback_valid", 32'(rx_valid), 32'(0));
        send(1, 1'b0, 2, 8'hA0, 1'b0);
        read_chk("rd_after_rollback", 1, 8'hA1);
        pop_one();

        // Fill the ring, drop a fifth, free one slot
        send(0, 1'b0, 1, 8'h20, 1'b0);
        send(0, 1'b0, 2, 8'h30, 1'b0);
        send(1, 1'b0, 3, 8'h50, 1'b0);
        send(0, 1'b1, 4, 8'h60, 1'b0);
        check("full_at_4", 32'(full), 32'(2'b11));
        check("depth_4", 32'(depth), 32'(4));
        send(1, 1'b0, 3, 8'h70, 1'b0);
        check("depth_after_drop", 32'(depth), 32'(4));
        pop_one();
        check("full_at_3", 32'(full), 32'(exp_full(enable, 2'b00, 3)));
        pop_one();

        // Simultaneous commit and pop at depth 2, across the pointer wrap
        send(1, 1'b0, 3, 8'h80, 1'b1);
        check("depth_push_pop", 32'(depth), 32'(2));
        read_chk("rd_head_wrap", 3, 8'h63);
        pop_one();
        pop_one();
        check("depth_drained", 32'(depth), 32'(0));

        // Overflow: 34 puts, last two land in the final slot
        send(0, 1'b0, 34, 8'h40, 1'b0);
        read_chk("ovf_first", 0, 8'h40);
        read_chk("ovf_last", 31, 8'h61);

        // Link reset mid-fill: no commit, committed packet kept
        start_pkt(1, 1'b0);
        for (int i = 0; i < 3; i++) put_byte(i, 8'hC0 + i);
        link_reset = 1'b1;
        tick();
        link_reset = 1'b0;
        acked = 1'b1;
        tick();
        acked = 1'b0;
        check("depth_after_link_reset", 32'(depth), 32'(1));
        pop_one();

        // Disabled and unimplemented endpoints are dropped
        enable = 2'b01;
        #1;
        check("full_disabled", 32'(full), 32'(2'b10));
        send(1, 1'b0, 2, 8'hD0, 1'b0);
        send(5, 1'b0, 2, 8'hD8, 1'b0);
        check("depth_after_disabled", 32'(depth), 32'(0));
        enable = 2'b11;

        // Occupancy 3: OUT vs SETUP on the last buffer
        send(1, 1'b0, 1, 8'h01, 1'b0);
        send(1, 1'b0, 1, 8'h02, 1'b0);
        send(1, 1'b0, 1, 8'h03, 1'b0);
        check("full_at_3_out", 32'(full), 32'(exp_full(enable, 2'b00, 3)));
        send(1, 1'b0, 2, 8'h04, 1'b0);
        send(0, 1'b1, 2, 8'h08, 1'b0);
        check("depth_4_setup", 32'(depth), 32'(4));
        while (mcnt > 0) pop_one();
        check("depth_final", 32'(depth), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
